// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit: main FSM with registered Moore
// controls, ALU decoder, condition flags register and condition check.
module mc_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Moore control bundle, registered together with the state so every
  // control is a flop output for the state it belongs to.
  typedef struct packed {
    logic       next_pc;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctl_t;

  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic [3:0] flags_q, flags_d;   // {N,Z,C,V}
  logic [1:0] flag_w;
  logic       no_write;
  logic       cond_ex;
  logic       pcs;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  // Per-state Moore control values; anything not listed stays 0.
  function automatic ctl_t moore_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
        c.ir_w = 1'b1; c.next_pc = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01; c.reg_w = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1; c.mem_w = 1'b1;
      end
      S_EXECR:  c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_src_b = 2'b01; c.alu_op = 1'b1;
      end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b = 2'b01; c.result_src = 2'b10; c.branch = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
    ctl_d = moore_ctl(state_d);
  end

  // State and Moore control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctl_q   <= moore_ctl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // ALU decoder; NoWrite follows the current Funct regardless of state.
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    no_write   = (cmd == 4'b1010);
    if (ctl_q.alu_op) begin
      case (cmd)
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: ALUControl = 2'b00;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & ((ALUControl == 2'b00) | (ALUControl == 2'b01));
      if (cmd == 4'b1010) flag_w = 2'b11;
    end
  end

  // Condition check against the stored flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags capture on the edge leaving an execute state, gated by CondEx.
  always_comb begin
    flags_d = flags_q;
    if (((state_q == S_EXECR) || (state_q == S_EXECI)) && cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Flags register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 4'b0000;
    else     flags_q <= flags_d;
  end

  // Write enables are held low for the whole of reset so an aborted
  // instruction cannot write anything.
  always_comb begin
    pcs       = (ctl_q.reg_w & (Rd == 4'hF)) | ctl_q.branch;
    PCWrite   = ~rst & (ctl_q.next_pc | (pcs & cond_ex));
    IRWrite   = ~rst & ctl_q.ir_w;
    RegWrite  = ~rst & ctl_q.reg_w & cond_ex & ~no_write;
    MemWrite  = ~rst & ctl_q.mem_w & cond_ex;
    AdrSrc    = ctl_q.adr_src;
    ALUSrcA   = ctl_q.alu_src_a;
    ALUSrcB   = ctl_q.alu_src_b;
    ResultSrc = ctl_q.result_src;
    ImmSrc    = Op;
    RegSrc    = {(Op == 2'b01), (Op == 2'b10)};
    state     = state_q;
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instructions followed by random
// instructions, every cycle compared against an instruction-level model.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Cond = '0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic [3:0] ALUFlags = '0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  // Model condition flags.
  bit mn, mz, mc, mv;

  // Expected state sequence of the instruction being run.
  logic [3:0] exp_q[$];

  mc_control_unit dut (
    .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c);
    case (c)
      4'd0:  return mz;
      4'd1:  return !mz;
      4'd2:  return mc;
      4'd3:  return !mc;
      4'd4:  return mn;
      4'd5:  return !mn;
      4'd6:  return mv;
      4'd7:  return !mv;
      4'd8:  return mc && !mz;
      4'd9:  return !mc || mz;
      4'd10: return mn == mv;
      4'd11: return mn != mv;
      4'd12: return !mz && (mn == mv);
      4'd13: return mz || (mn != mv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU operation selected by a data-processing cmd.
  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  // Expected {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} per state.
  function automatic logic [5:0] mux_of(input logic [3:0] s);
    case (s)
      4'd0, 4'd1: return 6'b0_1_10_10;
      4'd2:       return 6'b0_0_01_00;
      4'd3:       return 6'b1_0_00_00;
      4'd4:       return 6'b0_0_00_01;
      4'd5:       return 6'b1_0_00_00;
      4'd7:       return 6'b0_0_01_00;
      4'd9:       return 6'b0_0_01_10;
      default:    return 6'b0_0_00_00;
    endcase
  endfunction

  // Run one instruction from FETCH to its last state, checking each cycle.
  // Entered and left at #1 after a rising edge.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd,
                           input logic [3:0] af);
    logic [3:0] s;
    logic [3:0] cmd;
    logic [1:0] aluc;
    bit ok, pcw, irw, rgw, mmw;
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    cmd = f[4:1];
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (op)
      2'b00: begin
        exp_q.push_back(f[5] ? 4'd7 : 4'd6);
        exp_q.push_back(4'd8);
      end
      2'b01: begin
        exp_q.push_back(4'd2);
        if (f[0]) begin exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
        else exp_q.push_back(4'd5);
      end
      2'b10: exp_q.push_back(4'd9);
      default: ;
    endcase
    #1;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      ok = cond_ok(c);
      irw = (s == 0);
      pcw = (s == 0) || (ok && ((s == 9) || ((s == 4 || s == 8) && rd == 4'hF)));
      rgw = (s == 4 || s == 8) && ok && (cmd != 4'b1010);
      mmw = (s == 5) && ok;
      aluc = (s == 6 || s == 7) ? alu_of(cmd) : 2'b00;
      check("state", 32'(state), 32'(s));
      check("wen", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite},
            {28'd0, pcw, irw, rgw, mmw});
      check("mux", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc},
            {26'd0, mux_of(s)});
      check("dec", {26'd0, ImmSrc, RegSrc, ALUControl},
            {26'd0, op, (op == 2'b01), (op == 2'b10), aluc});
      if ((s == 6 || s == 7) && ok) begin
        if (f[0] || cmd == 4'b1010) begin
          mn = af[3]; mz = af[2];
        end
        if (cmd == 4'b1010 || (f[0] && alu_of(cmd) <= 2'b01)) begin
          mc = af[1]; mv = af[0];
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset in the middle of a store, at its MEMWR cycle.
  task automatic reset_in_memwr();
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    check("str_state", 32'(state), 32'd5);
    check("str_memw", 32'(MemWrite), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_memw", 32'(MemWrite), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_wen", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    mn = 0; mz = 0; mc = 0; mv = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    mn = 0; mz = 0; mc = 0; mv = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state0", 32'(state), 32'd0);
    check("rst_wen0", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    rst = 1'b0;

    // ADD immediate.
    run_instr(4'b1110, 2'b00, 6'b101000, 4'd3, 4'b0000);
    // LDR then STR.
    run_instr(4'b1110, 2'b01, 6'b011001, 4'd4, 4'b0000);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000);
    // CMP setting Z, then B EQ taken and B NE not taken.
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
    // Clear Z, then ADDS EQ must neither write nor touch flags.
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0000);
    run_instr(4'b0000, 2'b00, 6'b001001, 4'd5, 4'b1111);
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
    // Data processing into PC.
    run_instr(4'b1110, 2'b00, 6'b001000, 4'hF, 4'b0000);
    // Op=11 is a two-cycle no-op.
    run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);

    reset_in_memwr();

    for (int i = 0; i < 250; i++) begin
      logic [3:0] c;
      logic [3:0] rd;
      c  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      run_instr(c, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), rd,
                4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
